// File: rtl/serial_adder.sv
// Bit-serial ripple adder: one full-adder slice and a carry flop, LSB first, with start/busy/done handshake.
// Optional subtract mode is enabled by defining SERIAL_ADDER_SUB_EN (adds the sub input).

module serial_adder_ha (
    input  logic a_i,
    input  logic b_i,
    output logic s_o,
    output logic c_o
);
    assign s_o = a_i ^ b_i;
    assign c_o = a_i & b_i;
endmodule

// Full adder from two half-adder slices plus an OR, as in the original adder cell.
module serial_adder_fa (
    input  logic a_i,
    input  logic b_i,
    input  logic c_i,
    output logic s_o,
    output logic c_o
);
    logic s1;
    logic c1;
    logic c2;

    serial_adder_ha u_ha0 (
        .a_i (a_i),
        .b_i (b_i),
        .s_o (s1),
        .c_o (c1)
    );

    serial_adder_ha u_ha1 (
        .a_i (s1),
        .b_i (c_i),
        .s_o (s_o),
        .c_o (c2)
    );

    assign c_o = c1 | c2;
endmodule

module serial_adder #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
`ifdef SERIAL_ADDER_SUB_EN
    input  logic             sub,
`endif
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);
    localparam int unsigned CW = $clog2(WIDTH) + 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] a_sh_q, a_sh_d;
    logic [WIDTH-1:0] b_sh_q, b_sh_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             carry_q, carry_d;
    logic             cout_q, cout_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic             sub_sel;
    logic [WIDTH-1:0] b_ld;
    logic             carry_ld;
    logic             fa_s;
    logic             fa_c;

`ifdef SERIAL_ADDER_SUB_EN
    assign sub_sel = sub;
`else
    assign sub_sel = 1'b0;
`endif

    // Subtract is a + ~b + 1: invert B on load and force the carry in.
    assign b_ld     = sub_sel ? ~b : b;
    assign carry_ld = sub_sel ? 1'b1 : cin;

    serial_adder_fa u_fa (
        .a_i (a_sh_q[0]),
        .b_i (b_sh_q[0]),
        .c_i (carry_q),
        .s_o (fa_s),
        .c_o (fa_c)
    );

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            a_sh_q  <= '0;
            b_sh_q  <= '0;
            sum_q   <= '0;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_sh_q  <= a_sh_d;
            b_sh_q  <= b_sh_d;
            sum_q   <= sum_d;
            cnt_q   <= cnt_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    // Next-state and datapath update
    always_comb begin
        state_d = state_q;
        a_sh_d  = a_sh_q;
        b_sh_d  = b_sh_q;
        sum_d   = sum_q;
        cnt_d   = cnt_q;
        carry_d = carry_q;
        cout_d  = cout_q;
        busy_d  = 1'b0;
        done_d  = 1'b0;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    a_sh_d  = a;
                    b_sh_d  = b_ld;
                    carry_d = carry_ld;
                    cnt_d   = '0;
                    sum_d   = '0;
                    state_d = S_RUN;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_RUN: begin
                sum_d   = (sum_q >> 1) | (WIDTH'(fa_s) << (WIDTH - 1));
                a_sh_d  = a_sh_q >> 1;
                b_sh_d  = b_sh_q >> 1;
                carry_d = fa_c;
                cnt_d   = cnt_q + CW'(1);
                // Last slice: this edge processes bit WIDTH-1.
                if (cnt_q == CW'(WIDTH - 1)) begin
                    cout_d  = fa_c;
                    state_d = S_DONE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        busy_d = (state_d == S_RUN);
        done_d = (state_d == S_DONE);
    end

    assign busy = busy_q;
    assign done = done_q;
    assign sum  = sum_q;
    assign cout = cout_q;

endmodule

// File: tb/tb_serial_adder.sv
// Bench for serial_adder: WIDTH=8 instance with a result scoreboard, plus a WIDTH=1 instance.
module tb_serial_adder;
    localparam int unsigned W  = 8;
    localparam int unsigned W1 = W + 1;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         busy;
    logic         done;
    logic [W-1:0] sum;
    logic         cout;

    logic         start1;
    logic [0:0]   a1;
    logic [0:0]   b1;
    logic         cin1;
    logic         busy1;
    logic         done1;
    logic [0:0]   sum1;
    logic         cout1;
`ifdef SERIAL_ADDER_SUB_EN
    logic         sub;
    logic         sub1;
`endif

    int cyc    = 0;
    int n_chk  = 0;
    int n_pass = 0;

    typedef struct {
        logic [W-1:0] sum;
        logic         cout;
        int           due;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    serial_adder #(.WIDTH(W)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (a),
        .b     (b),
        .cin   (cin),
`ifdef SERIAL_ADDER_SUB_EN
        .sub   (sub),
`endif
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout)
    );

    serial_adder #(.WIDTH(1)) u_dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start1),
        .a     (a1),
        .b     (b1),
        .cin   (cin1),
`ifdef SERIAL_ADDER_SUB_EN
        .sub   (sub1),
`endif
        .busy  (busy1),
        .done  (done1),
        .sum   (sum1),
        .cout  (cout1)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    endtask

    // Scoreboard consumer: every done pulse must match the oldest accepted operation.
    always @(negedge clk) begin
        if (rst_n && done) begin
            chk("sb_nonempty", 32'(sb.size() != 0), 32'd1);
            if (sb.size() != 0) begin
                mon_e = sb.pop_front();
                chk("sb_sum", 32'(sum), 32'(mon_e.sum));
                chk("sb_cout", 32'(cout), 32'(mon_e.cout));
                chk("sb_latency", cyc, mon_e.due);
            end
        end
    end

    function automatic logic [W:0] model(input logic [W-1:0] ta, input logic [W-1:0] tb,
                                         input logic tc, input logic ts);
        logic [W-1:0] bb;
        bb = ts ? ~tb : tb;
        return W1'(ta) + W1'(bb) + W1'(ts ? 1'b1 : tc);
    endfunction

    task automatic push_exp(input logic [W:0] e);
        exp_t x;
        x.sum  = e[W-1:0];
        x.cout = e[W];
        x.due  = cyc + int'(W);
        sb.push_back(x);
    endtask

    // One operation: accept, check busy through RUN, done pulse, then held result.
    task automatic do_op(input logic [W-1:0] ta, input logic [W-1:0] tb,
                         input logic tc, input logic ts);
        logic [W:0] e;
        e = model(ta, tb, tc, ts);
        @(negedge clk);
        a = ta;
        b = tb;
        cin = tc;
`ifdef SERIAL_ADDER_SUB_EN
        sub = ts;
`endif
        start = 1'b1;
        @(posedge clk);
        #1;
        push_exp(e);
        start = 1'b0;
        for (int i = 0; i < int'(W); i++) begin
            @(negedge clk);
            chk("run_busy", 32'(busy), 32'd1);
            chk("run_done", 32'(done), 32'd0);
        end
        @(negedge clk);
        chk("done_pulse", 32'(done), 32'd1);
        chk("done_busy", 32'(busy), 32'd0);
        @(negedge clk);
        chk("hold_done", 32'(done), 32'd0);
        chk("hold_sum", 32'(sum), 32'(e[W-1:0]));
        chk("hold_cout", 32'(cout), 32'(e[W]));
    endtask

    initial begin
        logic [2:0] v1 [3];
        rst_n = 1'b0;
        start = 1'b0;
        a = '0;
        b = '0;
        cin = 1'b0;
        start1 = 1'b0;
        a1 = '0;
        b1 = '0;
        cin1 = 1'b0;
`ifdef SERIAL_ADDER_SUB_EN
        sub = 1'b0;
        sub1 = 1'b0;
`endif
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_sum", 32'(sum), 32'd0);
        chk("rst_cout", 32'(cout), 32'd0);
        chk("rst_busy1", 32'(busy1), 32'd0);
        chk("rst_done1", 32'(done1), 32'd0);
        rst_n = 1'b1;

        do_op(8'h5A, 8'h3C, 1'b0, 1'b0);
        do_op(8'hFF, 8'h01, 1'b0, 1'b0);
        do_op(8'hFF, 8'h00, 1'b1, 1'b0);

        // Back-to-back with start held; operands changed during RUN must not matter.
        @(negedge clk);
        a = 8'h01;
        b = 8'h01;
        cin = 1'b0;
        start = 1'b1;
        @(posedge clk);
        #1;
        push_exp(model(8'h01, 8'h01, 1'b0, 1'b0));
        a = 8'h80;
        b = 8'h80;
        repeat (W + 1) @(negedge clk);
        chk("b2b_done1", 32'(done), 32'd1);
        @(posedge clk);
        #1;
        push_exp(model(8'h80, 8'h80, 1'b0, 1'b0));
        start = 1'b0;
        @(negedge clk);
        chk("b2b_rerun", 32'(busy), 32'd1);
        repeat (W) @(negedge clk);
        chk("b2b_done2", 32'(done), 32'd1);
        @(negedge clk);
        chk("b2b_idle_busy", 32'(busy), 32'd0);
        chk("b2b_idle_done", 32'(done), 32'd0);

        // Reset in the 4th RUN cycle discards the operation; start during reset ignored.
        @(negedge clk);
        a = 8'h77;
        b = 8'h11;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("mid_busy", 32'(busy), 32'd1);
        rst_n = 1'b0;
        start = 1'b1;
        @(negedge clk);
        chk("mrst_busy", 32'(busy), 32'd0);
        chk("mrst_done", 32'(done), 32'd0);
        chk("mrst_sum", 32'(sum), 32'd0);
        chk("mrst_cout", 32'(cout), 32'd0);
        rst_n = 1'b1;
        start = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            chk("mrst_quiet", 32'({busy, done}), 32'd0);
        end
        do_op(8'h5A, 8'hC3, 1'b1, 1'b0);

        for (int i = 0; i < 4; i++) begin
            do_op(W'($urandom), W'($urandom), 1'($urandom), 1'b0);
        end

`ifdef SERIAL_ADDER_SUB_EN
        do_op(8'h10, 8'h01, 1'b0, 1'b1);
        do_op(8'h01, 8'h02, 1'b0, 1'b1);
        do_op(8'h33, 8'h33, 1'b1, 1'b1);
        do_op(8'h40, 8'h01, 1'b1, 1'b0);
`endif

        // WIDTH=1 instance: done one cycle after accept; {cout,sum} = a+b+cin.
        v1[0] = 3'b111;
        v1[1] = 3'b100;
        v1[2] = 3'b001;
        for (int i = 0; i < 3; i++) begin
            logic [1:0] e1;
            e1 = 2'(v1[i][2]) + 2'(v1[i][1]) + 2'(v1[i][0]);
            @(negedge clk);
            a1 = v1[i][2];
            b1 = v1[i][1];
            cin1 = v1[i][0];
            start1 = 1'b1;
            @(posedge clk);
            #1;
            start1 = 1'b0;
            @(negedge clk);
            chk("w1_busy", 32'(busy1), 32'd1);
            chk("w1_nodone", 32'(done1), 32'd0);
            @(negedge clk);
            chk("w1_done", 32'(done1), 32'd1);
            chk("w1_busy_low", 32'(busy1), 32'd0);
            chk("w1_sum", 32'(sum1), 32'(e1[0]));
            chk("w1_cout", 32'(cout1), 32'(e1[1]));
        end

        repeat (3) @(negedge clk);
        chk("sb_drained", 32'(sb.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
